// File: rtl/root_pkg.sv
// Shared definitions for the root scheduler: op encoding, iteration counts,
// result widths, FSM state type and the trial-power helper.
package root_pkg;

  localparam int OPND_W     = 32;
  localparam int ROOT_W     = 16;
  localparam int CBRT_W     = 11;
  localparam int REM_W      = 32;
  localparam int SQRT_ITERS = 16;
  localparam int CBRT_ITERS = 11;
  localparam int CALC_W     = 36;
  localparam int BIT_W      = 4;

  localparam logic OP_SQRT = 1'b0;
  localparam logic OP_CBRT = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  // Square or cube of a candidate root, wide enough that 2047^3 cannot wrap.
  function automatic logic [CALC_W-1:0] root_pow(input logic op,
                                                 input logic [ROOT_W-1:0] y);
    logic [CALC_W-1:0] x;
    x = CALC_W'(y);
    return (op == OP_CBRT) ? x * x * x : x * x;
  endfunction

endpackage

// File: rtl/root_iter_core.sv
// Restoring square/cube-root recurrence, one result bit per cycle, MSB first.
// Optional remainder output under macro ROOT_SCHEDULER_REM_EN.
module root_iter_core
  import root_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              op,
  input  logic [OPND_W-1:0] operand,
  output logic              done,
`ifdef ROOT_SCHEDULER_REM_EN
  output logic [REM_W-1:0]  rem,
`endif
  output logic [ROOT_W-1:0] root
);

  logic [OPND_W-1:0] n_q, n_d;
  logic [ROOT_W-1:0] y_q, y_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              op_q, op_d;
  logic              run_q, run_d;
  logic              done_q, done_d;
  logic [ROOT_W-1:0] trial;
  logic              fits;

  always_comb begin
    // NOTE: every variable gets its default first so no path can infer a latch.
    n_d    = n_q;
    y_d    = y_q;
    bit_d  = bit_q;
    op_d   = op_q;
    run_d  = run_q;
    done_d = done_q;
    trial  = y_q | (ROOT_W'(1) << bit_q);
    fits   = root_pow(op_q, trial) <= CALC_W'(n_q);

    if (start) begin
      n_d    = operand;
      op_d   = op;
      y_d    = '0;
      bit_d  = (op == OP_CBRT) ? BIT_W'(CBRT_ITERS - 1) : BIT_W'(SQRT_ITERS - 1);
      run_d  = 1'b1;
      done_d = 1'b0;
    end else if (run_q) begin
      if (fits) y_d = trial;
      if (bit_q == '0) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end else begin
        bit_d = bit_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments only, so every flop samples pre-edge values.
    if (rst) begin
      n_q    <= '0;
      y_q    <= '0;
      bit_q  <= '0;
      op_q   <= OP_SQRT;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      n_q    <= n_d;
      y_q    <= y_d;
      bit_q  <= bit_d;
      op_q   <= op_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign root = y_q;

`ifdef ROOT_SCHEDULER_REM_EN
  logic [CALC_W-1:0] y_pow;
  assign y_pow = root_pow(op_q, y_q);
  assign rem   = n_q - y_pow[REM_W-1:0];
`endif

endmodule

// File: rtl/root_scheduler.sv
// Round-robin front end sharing one root engine among NUM_REQ requesters.
// Define ROOT_SCHEDULER_REM_EN to add the rsp_rem remainder port.
module root_scheduler
  import root_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_op,
  input  logic [NUM_REQ*32-1:0] req_number,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  rsp_op,
  output logic [ROOT_W-1:0]     rsp_root,
`ifdef ROOT_SCHEDULER_REM_EN
  output logic [REM_W-1:0]      rsp_rem,
`endif
  output logic                  busy
);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   cur_id_q, cur_id_d;
  logic              cur_op_q, cur_op_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic              rsp_op_q, rsp_op_d;
  logic [ROOT_W-1:0] rsp_root_q, rsp_root_d;

  logic              gnt_any;
  logic [ID_W-1:0]   gnt_idx;
  logic [NUM_REQ-1:0] gnt_vec;
  logic              gnt_op;
  logic [OPND_W-1:0] gnt_num;
  logic              accept;
  logic              core_start;
  logic              core_done;
  logic [ROOT_W-1:0] core_root;
  int                idx;

  // Search begins at rr_ptr_q, which always holds (last granted + 1).
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    gnt_vec = '0;
    gnt_op  = OP_SQRT;
    gnt_num = '0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!gnt_any && req_valid[idx]) begin
        gnt_any      = 1'b1;
        gnt_idx      = ID_W'(idx);
        gnt_vec[idx] = 1'b1;
        gnt_op       = req_op[idx];
        gnt_num      = req_number[32*idx +: 32];
      end
    end
  end

  assign req_ready = (state_q == IDLE && !rst) ? gnt_vec : '0;
  assign accept    = |(req_ready & req_valid);

`ifdef ROOT_SCHEDULER_REM_EN
  logic [REM_W-1:0] rsp_rem_q, rsp_rem_d;
  logic [REM_W-1:0] core_rem;
`endif

  root_iter_core u_core (
    .clk     (clk),
    .rst     (rst),
    .start   (core_start),
    .op      (gnt_op),
    .operand (gnt_num),
    .done    (core_done),
`ifdef ROOT_SCHEDULER_REM_EN
    .rem     (core_rem),
`endif
    .root    (core_root)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cur_id_d    = cur_id_q;
    cur_op_d    = cur_op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_op_d    = rsp_op_q;
    rsp_root_d  = rsp_root_q;
`ifdef ROOT_SCHEDULER_REM_EN
    rsp_rem_d   = rsp_rem_q;
`endif
    core_start  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = CALC;
          core_start = 1'b1;
          cur_id_d   = gnt_idx;
          cur_op_d   = gnt_op;
          rr_ptr_d   = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end
      CALC: begin
        if (core_done) begin
          state_d     = DONE;
          rsp_valid_d = 1'b1;
          rsp_id_d    = cur_id_q;
          rsp_op_d    = cur_op_q;
          rsp_root_d  = core_root;
`ifdef ROOT_SCHEDULER_REM_EN
          rsp_rem_d   = core_rem;
`endif
        end
      end
      DONE: begin
        // req_ready is low here, so the handshake edge never overlaps an accept.
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      cur_id_q    <= '0;
      cur_op_q    <= OP_SQRT;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_op_q    <= OP_SQRT;
      rsp_root_q  <= '0;
`ifdef ROOT_SCHEDULER_REM_EN
      rsp_rem_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cur_id_q    <= cur_id_d;
      cur_op_q    <= cur_op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_op_q    <= rsp_op_d;
      rsp_root_q  <= rsp_root_d;
`ifdef ROOT_SCHEDULER_REM_EN
      rsp_rem_q   <= rsp_rem_d;
`endif
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_op    = rsp_op_q;
  assign rsp_root  = rsp_root_q;
`ifdef ROOT_SCHEDULER_REM_EN
  assign rsp_rem   = rsp_rem_q;
`endif
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_root_scheduler.sv
// Scoreboard bench for root_scheduler: randomized requests, behavioural root model.
// Remainder checks are compiled in when ROOT_SCHEDULER_REM_EN is defined.
module tb_root_scheduler;
  import root_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int ID_W    = 3;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ-1:0]    req_op = '0;
  logic [NUM_REQ*32-1:0] req_number = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b0;
  logic [ID_W-1:0]       rsp_id;
  logic                  rsp_op;
  logic [ROOT_W-1:0]     rsp_root;
  logic                  busy;
`ifdef ROOT_SCHEDULER_REM_EN
  logic [REM_W-1:0]      rsp_rem;
`endif

  root_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_number (req_number),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_op     (rsp_op),
    .rsp_root   (rsp_root),
`ifdef ROOT_SCHEDULER_REM_EN
    .rsp_rem    (rsp_rem),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    int          id;
    logic        op;
    logic [31:0] root;
    logic [31:0] rem;
    int unsigned acc;
  } exp_t;

  typedef struct {
    logic        op;
    logic [31:0] num;
  } txn_t;

  exp_t               sb[$];
  txn_t               pend[NUM_REQ][$];
  txn_t               cur[NUM_REQ];
  logic [NUM_REQ-1:0] act = '0;
  int                 rr_ptr = 0;
  int                 glog[$];
  int                 bp_hold = 0;
  bit                 rdy_rand = 1'b1;

  // Largest r with r^2 (or r^3) <= n, by binary search on 64-bit integers.
  function automatic longint unsigned ref_root(input logic op, input logic [31:0] n);
    longint unsigned lo, hi, mid, p;
    lo = 0;
    hi = op ? 64'd2048 : 64'd65536;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      p   = op ? mid * mid * mid : mid * mid;
      if (p <= 64'(n)) lo = mid;
      else hi = mid;
    end
    return lo;
  endfunction

  function automatic int outstanding();
    int s;
    s = sb.size();
    for (int i = 0; i < NUM_REQ; i++) s += pend[i].size() + int'(act[i]);
    return s;
  endfunction

  task automatic push(input int id, input logic op, input logic [31:0] num);
    txn_t t;
    t.op  = op;
    t.num = num;
    pend[id].push_back(t);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (outstanding() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("drain_outstanding", 64'(outstanding()), 0);
    repeat (2) @(negedge clk);
  endtask

  // Request driver and reference arbiter.
  initial begin : driver
    int win, idx;
    logic [NUM_REQ-1:0] expv;
    exp_t e;
    longint unsigned r;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!act[i] && pend[i].size() > 0) begin
          cur[i] = pend[i].pop_front();
          act[i] = 1'b1;
        end
        req_op[i]             = act[i] ? cur[i].op : 1'($urandom_range(0, 1));
        req_number[32*i +: 32] = act[i] ? cur[i].num : $urandom;
      end
      req_valid = act;
      #1;
      win = -1;
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (rr_ptr + k) % NUM_REQ;
        if (win < 0 && act[idx]) win = idx;
      end
      if (act == '0) begin
        check("ready_without_valid", 64'(req_ready), 0);
      end else if (req_ready != '0) begin
        expv = '0;
        expv[win] = 1'b1;
        check("rr_grant", 64'(req_ready), 64'(expv));
        for (int i = 0; i < NUM_REQ; i++) begin
          if (req_ready[i] && act[i]) begin
            r      = ref_root(cur[i].op, cur[i].num);
            e.id   = i;
            e.op   = cur[i].op;
            e.root = 32'(r);
            e.rem  = cur[i].op ? cur[i].num - 32'(r * r * r) : cur[i].num - 32'(r * r);
            e.acc  = cyc + 1;
            sb.push_back(e);
            glog.push_back(i);
            rr_ptr = (i + 1) % NUM_REQ;
            act[i] = 1'b0;
          end
        end
      end
    end
  end

  // Response consumer: optional forced stall, otherwise random or always ready.
  initial begin : consumer
    forever begin
      @(negedge clk);
      if (rsp_valid && bp_hold > 0) begin
        rsp_ready = 1'b0;
        bp_hold--;
      end else begin
        rsp_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // Monitor: compares every presented response against the scoreboard head.
  initial begin : monitor
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev = 1'b0;
        continue;
      end
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", 64'(rsp_valid), 0);
        end else begin
          e = sb[0];
          check("rsp_id", 64'(rsp_id), 64'(e.id));
          check("rsp_op", 64'(rsp_op), 64'(e.op));
          check("rsp_root", 64'(rsp_root), 64'(e.root));
`ifdef ROOT_SCHEDULER_REM_EN
          check("rsp_rem", 64'(rsp_rem), 64'(e.rem));
`endif
          check("busy_in_done", 64'(busy), 1);
          check("ready_in_done", 64'(req_ready), 0);
          if (!prev) check("latency", 64'(cyc - e.acc), e.op ? 64'd12 : 64'd17);
          if (rsp_ready) e = sb.pop_front();
        end
      end
      prev = rsp_valid;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin : main
    int t;
    logic [31:0] num;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    check("reset_rsp_valid", 64'(rsp_valid), 0);
    check("reset_busy", 64'(busy), 0);
    check("reset_req_ready", 64'(req_ready), 0);
    check("reset_rsp_id", 64'(rsp_id), 0);
    check("reset_rsp_op", 64'(rsp_op), 0);
    check("reset_rsp_root", 64'(rsp_root), 0);
`ifdef ROOT_SCHEDULER_REM_EN
    check("reset_rsp_rem", 64'(rsp_rem), 0);
`endif
    rst = 1'b0;

    push(0, OP_SQRT, 32'd100);        drain();
    push(1, OP_CBRT, 32'd1000);       drain();
    push(0, OP_SQRT, 32'hFFFFFFFF);   drain();
    push(1, OP_CBRT, 32'hFFFFFFFF);   drain();
    push(0, OP_SQRT, 32'd0);          drain();
    push(1, OP_CBRT, 32'd0);          drain();
    push(1, OP_SQRT, 32'd50);         drain();

    glog.delete();
    for (int i = 0; i < 4; i++) begin
      push(0, OP_SQRT, $urandom);
      push(1, OP_CBRT, $urandom);
    end
    drain();
    check("contention_grant0", 64'(glog[0]), 0);
    check("contention_grant1", 64'(glog[1]), 1);
    check("contention_grant2", 64'(glog[2]), 0);
    check("contention_grant3", 64'(glog[3]), 1);

    rdy_rand = 1'b0;
    bp_hold  = 5;
    push(0, OP_CBRT, 32'd343);
    push(1, OP_SQRT, 32'd144);
    drain();
    check("backpressure_consumed", 64'(bp_hold), 0);
    rdy_rand = 1'b1;

    push(0, OP_SQRT, 32'd12345678);
    t = 0;
    while (sb.size() == 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("abort_req_accepted", 64'(sb.size()), 1);
    repeat (5) @(negedge clk);
    #3;
    rst = 1'b1;
    sb.delete();
    rr_ptr = 0;
    @(negedge clk);
    #3;
    rst = 1'b0;
    check("abort_busy", 64'(busy), 0);
    check("abort_rsp_valid", 64'(rsp_valid), 0);
    repeat (25) @(negedge clk);
    glog.delete();
    push(0, OP_CBRT, 32'd27);
    push(1, OP_CBRT, 32'd27);
    drain();
    check("post_reset_first_grant", 64'(glog[0]), 0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       num = $urandom;
        1:       num = $urandom_range(0, 1000);
        2:       num = 32'hFFFFFFFF - $urandom_range(0, 100);
        default: begin
          num = $urandom_range(0, 2000);
          num = num * num;
        end
      endcase
      push(int'($urandom_range(0, NUM_REQ - 1)), 1'($urandom_range(0, 1)), num);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
